// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine over a variable-latency req/ack port.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] data2_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  mem_ctrl_in,
    input  logic [1:0]  mem_size_in,
    input  logic        wb_ctrl_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_out,
    output logic        wb_ctrl_out,
    output logic [1:0]  mem_err_out
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        uns_q, uns_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_ctrl_q, wb_ctrl_d;
    logic [1:0]  err_q, err_d;

    logic        is_rd, is_wr, is_ill, misal, issue, timeout;
    logic [1:0]  lane_n;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n;
    logic [31:0] shifted, load_val;

    // Decode the incoming op and build the lane-placed store bundle.
    always_comb begin
        is_rd  = (mem_ctrl_in[1:0] == 2'b01);
        is_wr  = (mem_ctrl_in[1:0] == 2'b10);
        is_ill = (mem_ctrl_in[1:0] == 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
        misal  = ((mem_size_in == 2'b01) && alu_res_in[0]) ||
                 (mem_size_in[1] && (alu_res_in[1:0] != 2'b00));
`else
        misal  = 1'b0;
`endif
        issue  = (is_rd || is_wr) && !misal;
        lane_n  = 2'b00;
        strb_n  = 4'b1111;
        wdata_n = data2_in;
        unique case (mem_size_in)
            2'b00: begin
                lane_n  = alu_res_in[1:0];
                strb_n  = 4'b0001 << alu_res_in[1:0];
                wdata_n = {4{data2_in[7:0]}};
            end
            2'b01: begin
                lane_n  = {alu_res_in[1], 1'b0};
                strb_n  = 4'b0011 << {alu_res_in[1], 1'b0};
                wdata_n = {2{data2_in[15:0]}};
            end
            default: begin
                lane_n  = 2'b00;
                strb_n  = 4'b1111;
                wdata_n = data2_in;
            end
        endcase
    end

    // Extract and extend the load result from the returned word.
    always_comb begin
        shifted  = dmem_rdata >> {lane_q, 3'b000};
        load_val = dmem_rdata;
        unique case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_q ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    // Freeze request: pending issue in IDLE, or WAIT until ack/timeout.
    always_comb begin
        timeout   = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
        stall_out = (state_q == S_IDLE) ? issue : !(dmem_ack || timeout);
    end

    // Next-state and MEM/WB result selection.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        lane_d    = lane_q;
        uns_d     = uns_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        rd_d      = rd_q;
        wb_ctrl_d = 1'b0;
        err_d     = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                wb_data_d = alu_res_in;
                rd_d      = rd_in;
                if (is_ill) begin
                    err_d = 2'b11;
                end else if (issue) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = is_wr;
                    addr_d  = {alu_res_in[31:2], 2'b00};
                    wdata_d = wdata_n;
                    wstrb_d = strb_n;
                    size_d  = mem_size_in;
                    lane_d  = lane_n;
                    uns_d   = mem_ctrl_in[2];
                    cnt_d   = 16'd0;
                end else if (is_rd || is_wr) begin
                    err_d = 2'b10;
                end else begin
                    wb_ctrl_d = wb_ctrl_in;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    wb_data_d = we_q ? alu_res_in : load_val;
                    rd_d      = rd_in;
                    wb_ctrl_d = wb_ctrl_in;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    wb_data_d = 32'd0;
                    rd_d      = rd_in;
                    err_d     = 2'b01;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            size_q    <= 2'd0;
            lane_q    <= 2'd0;
            uns_q     <= 1'b0;
            cnt_q     <= 16'd0;
            wb_data_q <= 32'd0;
            rd_q      <= 5'd0;
            wb_ctrl_q <= 1'b0;
            err_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            lane_q    <= lane_d;
            uns_q     <= uns_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            rd_q      <= rd_d;
            wb_ctrl_q <= wb_ctrl_d;
            err_q     <= err_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_wstrb  = wstrb_q;
    assign wb_data_out = wb_data_q;
    assign rd_out      = rd_q;
    assign wb_ctrl_out = wb_ctrl_q;
    assign mem_err_out = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table plus randomized ops against a reference model.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_unit;

    localparam int T = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res_in, data2_in;
    logic [4:0]  rd_in;
    logic [2:0]  mem_ctrl_in;
    logic [1:0]  mem_size_in;
    logic        wb_ctrl_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        wb_ctrl_out;
    logic [1:0]  mem_err_out;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .alu_res_in(alu_res_in), .data2_in(data2_in), .rd_in(rd_in),
        .mem_ctrl_in(mem_ctrl_in), .mem_size_in(mem_size_in),
        .wb_ctrl_in(wb_ctrl_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_data_out(wb_data_out), .rd_out(rd_out),
        .wb_ctrl_out(wb_ctrl_out), .mem_err_out(mem_err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [2:0]  ctrl;
        logic [1:0]  size;
        logic        wb;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] e_data;
        logic [1:0]  e_err;
        logic        e_wbc;
        logic        chk_data;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
        input logic [2:0] ctrl, input logic [1:0] size, input logic wb,
        input int dly, input logic [31:0] rdata, input logic [31:0] e_data,
        input logic [1:0] e_err, input logic e_wbc, input logic chk_data,
        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_strb);
        vec_t r;
        r.addr = addr; r.data = data; r.rd = rd; r.ctrl = ctrl;
        r.size = size; r.wb = wb; r.dly = dly; r.rdata = rdata;
        r.e_data = e_data; r.e_err = e_err; r.e_wbc = e_wbc;
        r.chk_data = chk_data; r.e_addr = e_addr;
        r.e_wdata = e_wdata; r.e_strb = e_strb;
        return r;
    endfunction

    // Reference model: derive every expectation from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int nb, off;
        logic [31:0] raw, mask;
        r = v;
        nb = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
        off = int'(v.addr % 4);
        off = off - (off % nb);
        r.e_addr = v.addr & ~32'h3;
        r.e_strb = 4'b0000;
        for (int i = 0; i < nb; i++) r.e_strb[off + i] = 1'b1;
        for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.data[8*(i % nb) +: 8];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        raw = (v.rdata >> (8 * off)) & mask;
        if (!v.ctrl[2] && nb < 4 && raw[8*nb-1]) raw = raw | ~mask;
        r.chk_data = 1'b1;
        r.e_err = 2'b00;
        r.e_wbc = v.wb;
        r.e_data = v.addr;
        if (v.ctrl[1:0] == 2'b11) begin
            r.e_err = 2'b11; r.e_wbc = 1'b0; r.chk_data = 1'b0;
        end else if (v.ctrl[1:0] == 2'b00) begin
            r.e_data = v.addr;
        end else if (TRAP && (v.addr % nb) != 0) begin
            r.e_err = 2'b10; r.e_wbc = 1'b0; r.chk_data = 1'b0;
        end else if (v.dly < 0 || v.dly >= T) begin
            r.e_err = 2'b01; r.e_wbc = 1'b0; r.e_data = 32'd0;
        end else if (v.ctrl[0]) begin
            r.e_data = raw;
        end
        return r;
    endfunction

    // Present one op, play the memory side, check every cycle and the result.
    task automatic do_op(input vec_t v);
        logic memop;
        bit   fin;
        int   k;
        memop = (v.ctrl[1:0] == 2'b01 || v.ctrl[1:0] == 2'b10) && (v.e_err != 2'b10);
        alu_res_in  = v.addr;
        data2_in    = v.data;
        rd_in       = v.rd;
        mem_ctrl_in = v.ctrl;
        mem_size_in = v.size;
        wb_ctrl_in  = v.wb;
        dmem_ack    = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(stall_out), 32'(memop));
        chk("idle_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (memop) begin
            k = 0;
            fin = 1'b0;
            while (!fin) begin
                fin = (k == v.dly) || (k == T - 1);
                dmem_ack = (k == v.dly);
                dmem_rdata = (k == v.dly) ? v.rdata : $urandom;
                @(negedge clk);
                chk("wait_req", 32'(dmem_req), 32'd1);
                chk("wait_we", 32'(dmem_we), 32'(v.ctrl[1]));
                chk("wait_addr", dmem_addr, v.e_addr);
                if (v.ctrl[1]) begin
                    chk("wait_wdata", dmem_wdata, v.e_wdata);
                    chk("wait_wstrb", 32'(dmem_wstrb), 32'(v.e_strb));
                end
                chk("wait_stall", 32'(stall_out), 32'(!fin));
                chk("wait_err", 32'(mem_err_out), 32'd0);
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                k++;
            end
            chk("done_req", 32'(dmem_req), 32'd0);
        end
        chk("res_err", 32'(mem_err_out), 32'(v.e_err));
        chk("res_wbc", 32'(wb_ctrl_out), 32'(v.e_wbc));
        if (v.chk_data) begin
            chk("res_data", wb_data_out, v.e_data);
            chk("res_rd", 32'(rd_out), 32'(v.rd));
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1;
        alu_res_in = '0; data2_in = '0; rd_in = '0;
        mem_ctrl_in = '0; mem_size_in = '0; wb_ctrl_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #2;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_wbdata", wb_data_out, 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_wbc", 32'(wb_ctrl_out), 32'd0);
        chk("rst_err", 32'(mem_err_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        tbl.push_back(mk(32'h1234, 32'h0, 5, 3'b000, 2'b10, 1, -1, 32'h0,
                         32'h1234, 2'b00, 1, 1, 32'h0, 32'h0, 4'h0));
        tbl.push_back(mk(32'h103, 32'h0, 7, 3'b001, 2'b00, 1, 3, 32'h80FF_0000,
                         32'hFFFF_FF80, 2'b00, 1, 1, 32'h100, 32'h0, 4'h0));
        tbl.push_back(mk(32'h103, 32'h0, 7, 3'b101, 2'b00, 1, 3, 32'h80FF_0000,
                         32'h0000_0080, 2'b00, 1, 1, 32'h100, 32'h0, 4'h0));
        tbl.push_back(mk(32'h202, 32'hABCD, 3, 3'b010, 2'b01, 0, 1, 32'h0,
                         32'h202, 2'b00, 0, 1, 32'h200, 32'hABCD_ABCD, 4'b1100));
        tbl.push_back(mk(32'h40, 32'h0, 4, 3'b001, 2'b10, 1, -1, 32'h1234_5678,
                         32'h0, 2'b01, 0, 1, 32'h40, 32'h0, 4'h0));
        tbl.push_back(mk(32'h40, 32'h0, 4, 3'b001, 2'b10, 1, 3, 32'h1122_3344,
                         32'h1122_3344, 2'b00, 1, 1, 32'h40, 32'h0, 4'h0));
        tbl.push_back(mk(32'h55, 32'h0, 9, 3'b011, 2'b10, 1, 0, 32'h0,
                         32'h0, 2'b11, 0, 0, 32'h0, 32'h0, 4'h0));
        if (TRAP)
            tbl.push_back(mk(32'h101, 32'h0, 10, 3'b001, 2'b10, 1, 0, 32'hDEAD_BEEF,
                             32'h0, 2'b10, 0, 0, 32'h100, 32'h0, 4'h0));
        else
            tbl.push_back(mk(32'h101, 32'h0, 10, 3'b001, 2'b10, 1, 0, 32'hDEAD_BEEF,
                             32'hDEAD_BEEF, 2'b00, 1, 1, 32'h100, 32'h0, 4'h0));
        tbl.push_back(mk(32'h106, 32'h0, 11, 3'b001, 2'b01, 1, 2, 32'h8001_7FFF,
                         32'hFFFF_8001, 2'b00, 1, 1, 32'h104, 32'h0, 4'h0));
        tbl.push_back(mk(32'h102, 32'h0, 12, 3'b101, 2'b01, 1, 1, 32'h8001_7FFF,
                         32'h0000_8001, 2'b00, 1, 1, 32'h100, 32'h0, 4'h0));
        tbl.push_back(mk(32'h301, 32'h1234_5678, 13, 3'b010, 2'b00, 0, 0, 32'h0,
                         32'h301, 2'b00, 0, 1, 32'h300, 32'h7878_7878, 4'b0010));
        tbl.push_back(mk(32'h400, 32'hCAFE_F00D, 14, 3'b010, 2'b11, 0, 2, 32'h0,
                         32'h400, 2'b00, 0, 1, 32'h400, 32'hCAFE_F00D, 4'b1111));
        for (int i = 0; i < tbl.size(); i++) do_op(tbl[i]);

        // Reset while an access is outstanding.
        alu_res_in = 32'h80; mem_ctrl_in = 3'b001; mem_size_in = 2'b10;
        rd_in = 5'd6; wb_ctrl_in = 1'b1; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_up", 32'(dmem_req), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        mem_ctrl_in = 3'b000;
        #1;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_addr", dmem_addr, 32'd0);
        chk("mid_rst_wbdata", wb_data_out, 32'd0);
        chk("mid_rst_wbc", 32'(wb_ctrl_out), 32'd0);
        chk("mid_rst_err", 32'(mem_err_out), 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_op(tbl[5]);

        for (int n = 0; n < 300; n++) begin
            rv.addr  = $urandom;
            rv.data  = $urandom;
            rv.rd    = 5'($urandom);
            rv.ctrl  = 3'($urandom);
            rv.size  = 2'($urandom);
            rv.wb    = 1'($urandom);
            rv.dly   = int'($urandom_range(0, 6)) - 1;
            rv.rdata = $urandom;
            do_op(model(rv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
